// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_pkg
//  Description : Shared widths and state encodings for the compute core.
//  Revision    : 1.0  initial release
// ============================================================================
package gpu_pkg;

    localparam int THREADS_PER_BLOCK  = 4;
    localparam int DATA_MEM_ADDR_BITS = 8;
    localparam int DATA_MEM_DATA_BITS = 8;

    // LSU memory arbiter: grant, memory access, response hold
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_MEM     = 2'd1,
        ARB_RELEASE = 2'd2
    } lsu_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin search. Returns the first set bit
//                of the eligible mask starting at rr_ptr and wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] w_idx;

    // Scan offsets from farthest to nearest so the nearest eligible index wins
    always_comb begin
        found  = 1'b0;
        winner = '0;
        w_idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = IDX_W'((int'(rr_ptr) + i) % N);
            if (eligible[w_idx]) begin
                found  = 1'b1;
                winner = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_arbiter
//  Description : Round-robin arbiter sharing one data-memory channel between
//                per-thread LSUs. 4-phase handshake toward the LSUs,
//                valid/ready toward memory, one transaction at a time.
//                Optional statistics counters enabled by LSU_ARB_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_mem_arbiter
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK  = gpu_pkg::THREADS_PER_BLOCK,
    parameter int DATA_MEM_ADDR_BITS = gpu_pkg::DATA_MEM_ADDR_BITS,
    parameter int DATA_MEM_DATA_BITS = gpu_pkg::DATA_MEM_DATA_BITS
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic [THREADS_PER_BLOCK-1:0]                         active_threads,
    input  logic [THREADS_PER_BLOCK-1:0]                         req_valid,
    input  logic [THREADS_PER_BLOCK-1:0]                         req_we,
    input  logic [THREADS_PER_BLOCK-1:0][DATA_MEM_ADDR_BITS-1:0] req_addr,
    input  logic [THREADS_PER_BLOCK-1:0][DATA_MEM_DATA_BITS-1:0] req_wdata,
    output logic [THREADS_PER_BLOCK-1:0]                         rsp_valid,
    output logic [THREADS_PER_BLOCK-1:0][DATA_MEM_DATA_BITS-1:0] rsp_rdata,
    output logic                                                 mem_read_valid,
    output logic [DATA_MEM_ADDR_BITS-1:0]                        mem_read_addr,
    input  logic                                                 mem_read_ready,
    input  logic [DATA_MEM_DATA_BITS-1:0]                        mem_read_data,
    output logic                                                 mem_write_valid,
    output logic [DATA_MEM_ADDR_BITS-1:0]                        mem_write_addr,
    output logic [DATA_MEM_DATA_BITS-1:0]                        mem_write_data,
    input  logic                                                 mem_write_ready,
    output logic                                                 busy
`ifdef LSU_ARB_STATS_EN
    ,
    output logic [THREADS_PER_BLOCK-1:0][15:0]                   grant_count,
    output logic [15:0]                                          stall_cycles
`endif
);

    localparam int IDX_W = (THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1;

    lsu_arb_state_t              r_state;
    logic [IDX_W-1:0]            r_rr_ptr;
    logic [IDX_W-1:0]            r_winner;
    logic                        r_we;

    logic [THREADS_PER_BLOCK-1:0] w_eligible;
    logic                         w_found;
    logic [IDX_W-1:0]             w_pick;
    logic                         w_ready;
    logic [IDX_W-1:0]             w_next_ptr;

    assign w_eligible = req_valid & active_threads;
    // Only the ready of the direction actually in flight matters
    assign w_ready    = r_we ? mem_write_ready : mem_read_ready;
    assign w_next_ptr = (r_winner == IDX_W'(THREADS_PER_BLOCK - 1)) ? '0 : r_winner + 1'b1;

    rr_picker #(
        .N     (THREADS_PER_BLOCK),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .eligible (w_eligible),
        .rr_ptr   (r_rr_ptr),
        .found    (w_found),
        .winner   (w_pick)
    );

    // Arbitration FSM with all handshake outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ARB_IDLE;
            r_rr_ptr        <= '0;
            r_winner        <= '0;
            r_we            <= 1'b0;
            rsp_valid       <= '0;
            rsp_rdata       <= '0;
            mem_read_valid  <= 1'b0;
            mem_read_addr   <= '0;
            mem_write_valid <= 1'b0;
            mem_write_addr  <= '0;
            mem_write_data  <= '0;
            busy            <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_state  <= ARB_MEM;
                        busy     <= 1'b1;
                        r_winner <= w_pick;
                        r_we     <= req_we[w_pick];
                        if (req_we[w_pick]) begin
                            mem_write_valid <= 1'b1;
                            mem_write_addr  <= req_addr[w_pick];
                            mem_write_data  <= req_wdata[w_pick];
                        end else begin
                            mem_read_valid  <= 1'b1;
                            mem_read_addr   <= req_addr[w_pick];
                        end
                    end
                end
                ARB_MEM: begin
                    if (w_ready) begin
                        r_state             <= ARB_RELEASE;
                        mem_read_valid      <= 1'b0;
                        mem_write_valid     <= 1'b0;
                        r_rr_ptr            <= w_next_ptr;
                        rsp_valid[r_winner] <= 1'b1;
                        rsp_rdata[r_winner] <= r_we ? '0 : mem_read_data;
                    end
                end
                ARB_RELEASE: begin
                    // Winner completes regardless of its active bit
                    if (!req_valid[r_winner]) begin
                        r_state   <= ARB_IDLE;
                        busy      <= 1'b0;
                        rsp_valid <= '0;
                        rsp_rdata <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef LSU_ARB_STATS_EN
    // Saturating per-thread grant counts and memory ready-stall cycle count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_count  <= '0;
            stall_cycles <= '0;
        end else if (r_state == ARB_MEM) begin
            if (w_ready) begin
                if (grant_count[r_winner] != 16'hFFFF)
                    grant_count[r_winner] <= grant_count[r_winner] + 16'd1;
            end else if (stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
- Shares one data-memory channel between the per-thread LSUs of a compute core. Requests are served one at a time, round-robin.
- Sits between the thread LSUs and the core's data-memory port.
- Gates requests with the scheduler's active-thread mask.
- Uses a 4-phase request/response handshake toward the LSUs and a valid/ready handshake toward memory.

Parameters:
- THREADS_PER_BLOCK, 4, number of requesters (one per thread)
- DATA_MEM_ADDR_BITS, 8, memory address width
- DATA_MEM_DATA_BITS, 8, memory data width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- active_threads  in  THREADS_PER_BLOCK  active mask from scheduler; inactive requesters are ignored
- req_valid  in  THREADS_PER_BLOCK  per-thread request, held until rsp_valid is seen
- req_we  in  THREADS_PER_BLOCK  1=write, 0=read
- req_addr  in  [THREADS_PER_BLOCK][DATA_MEM_ADDR_BITS]  request address
- req_wdata  in  [THREADS_PER_BLOCK][DATA_MEM_DATA_BITS]  write data
- rsp_valid  out  THREADS_PER_BLOCK  one-hot, transaction complete
- rsp_rdata  out  [THREADS_PER_BLOCK][DATA_MEM_DATA_BITS]  read data (0 for writes)
- mem_read_valid  out  1;  mem_read_addr  out  DATA_MEM_ADDR_BITS
- mem_read_ready  in  1;  mem_read_data  in  DATA_MEM_DATA_BITS
- mem_write_valid  out  1;  mem_write_addr  out  DATA_MEM_ADDR_BITS;  mem_write_data  out  DATA_MEM_DATA_BITS
- mem_write_ready  in  1
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, active-low): all outputs 0; state IDLE; rr_ptr 0; latched winner, addr, data and rdata cleared. Reset mid-transaction abandons it with no response.
- Eligible request: eligible[t] = req_valid[t] & active_threads[t].

FSM states and transitions:
- IDLE: if any eligible bit is set, pick the first eligible index searching rr_ptr, rr_ptr+1, ... modulo THREADS_PER_BLOCK.
  - Latch winner, we, addr and wdata.
  - Go to MEM.
- MEM: drive mem_read_valid or mem_write_valid (per latched we) with the latched addr/data, held stable.
  - On mem_*_ready=1, capture mem_read_data (reads only) at that edge.
  - Set rr_ptr = (winner+1) mod THREADS_PER_BLOCK.
  - Go to RELEASE. The valid deasserts in the same transition.
- RELEASE: hold rsp_valid[winner]=1 and rsp_rdata[winner]=captured data.
  - When req_valid[winner]=0, go to IDLE; rsp_valid drops the next cycle.

Timing and handshake rules:
- Latency: req_valid asserted in cycle 0 gives mem valid in cycle 1. With ready in cycle 1, rsp_valid is high in cycle 2. Minimum is 2 cycles; each ready-stall cycle adds 1.
- mem_read_valid and mem_write_valid are never both high.
- Memory addr/data are stable while valid is high.
- A winner that becomes inactive in MEM or RELEASE still completes.
- New requests arriving during MEM or RELEASE wait; no preemption.
- The ready input of the non-selected direction is ignored.
- rsp_rdata of non-winners is 0.
- rr_ptr wraps from THREADS_PER_BLOCK-1 to 0.

Optional Feature:
- Macro LSU_ARB_STATS_EN.
- When defined, add output grant_count [THREADS_PER_BLOCK][15:0]: a per-thread counter incremented on the MEM→RELEASE edge, saturating at 16'hFFFF and reset to 0.
- Also add output stall_cycles [15:0]: incremented in each MEM cycle where ready=0, saturating.
- When not defined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- gpu_pkg gains the enum lsu_arb_state_t {ARB_IDLE, ARB_MEM, ARB_RELEASE}.
- Shared width parameters remain in gpu_pkg.
- One sub-module: rr_picker, purely combinational. Inputs are the eligible mask and rr_ptr; outputs are a found flag and the winner index.

Test Plan:
1. Single read: active=4'b1111; req_valid[2]=1, addr 0x10; mem_read_ready=1 in cycle 1 with data 0xAB → mem_read_valid/addr 0x10 in cycle 1; rsp_valid=4'b0100 with rsp_rdata[2]=0xAB from cycle 2, held until req_valid[2] drops, then low one cycle later.
2. Contention: all four requesting from reset, memory always ready → service order 0,1,2,3; rr_ptr returns to 0 afterward.
3. Wrap: after serving thread 2, requests on threads 0 and 3 → thread 3 is served first, then thread 0.
4. Stalled write: thread 1 writes 0x5A to 0x20; mem_write_ready held low 3 cycles → mem_write_valid/addr/data stable for 4 cycles; mem_read_valid stays 0; then rsp_valid[1]=1 with rsp_rdata[1]=0.
5. Masking: active=4'b0011, req_valid=4'b1100 → no memory valid, busy=0. Then setting active=4'b1111 → thread 2 is granted the next cycle.
6. Reset mid-MEM: reset low while mem_read_valid=1 → all outputs 0 immediately; after release the FSM is in IDLE with rr_ptr=0 and any held request is re-arbitrated.
